demux_seq_wb: RTL and testbench

Write-back sequencer, the return path of the mux read sequencer: accepts the paired o1/o2 output stream produced by the vector datapath, de-interleaves its lanes back into per-bank layout, and generates write addresses and write enables for the a0/a1 BRAM banks (mode 0) or the b0/c1 URAM banks (mode 1). It sits between the VPU/addx output and the polynomial storage. It counts one full polynomial of beats per job and reports completion and protocol errors.

---
 rtl/demux_seq_wb_pkg.sv | 29 ++
 rtl/demux_lane_map.sv | 28 ++
 rtl/demux_seq_wb.sv | 158 +++++++++++++++
 tb/tb_demux_seq_wb.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_seq_wb_pkg.sv
// Shared constants, mode encoding and state type for the mux/demux sequencers.
package demux_seq_wb_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned A1_BASE    = 2048;
  localparam int unsigned BEATS_M0   = 2048;
  localparam int unsigned BEATS_M1   = 4096;
  localparam int unsigned LANES      = 4;

  localparam logic MODE_A  = 1'b0;
  localparam logic MODE_BC = 1'b1;

  // Output bank select for the lane helper
  localparam int unsigned SEL_X0 = 0;
  localparam int unsigned SEL_X1 = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bank lane k takes its data from group (k%2 ? o2 : o1), lane 2*(k/2)+sel
  function automatic int unsigned src_lane(input int unsigned sel, input int unsigned k);
    return 2 * (k / 2) + sel;
  endfunction

endpackage

// File: rtl/demux_lane_map.sv
// Combinational de-interleave of the o1/o2 output groups into x0/x1 bank layout.
module demux_lane_map
  import demux_seq_wb_pkg::*;
#(
  parameter int unsigned DW = DATA_WIDTH
) (
  input  logic [4*DW-1:0] i_o1,
  input  logic [4*DW-1:0] i_o2,
  output logic [4*DW-1:0] o_x0,
  output logic [4*DW-1:0] o_x1
);

  // Even bank lanes come from o1, odd bank lanes from o2
  always_comb begin
    o_x0 = '0;
    o_x1 = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (k % 2 == 0) begin
        o_x0[k*DW +: DW] = i_o1[src_lane(SEL_X0, k)*DW +: DW];
        o_x1[k*DW +: DW] = i_o1[src_lane(SEL_X1, k)*DW +: DW];
      end else begin
        o_x0[k*DW +: DW] = i_o2[src_lane(SEL_X0, k)*DW +: DW];
        o_x1[k*DW +: DW] = i_o2[src_lane(SEL_X1, k)*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/demux_seq_wb.sv
// Write-back sequencer: de-interleaves paired o1/o2 beats and writes one
// polynomial per job into the a0/a1 or b0/c1 banks.
module demux_seq_wb
  import demux_seq_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = demux_seq_wb_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = demux_seq_wb_pkg::ADDR_WIDTH,
  parameter int unsigned A1_BASE    = demux_seq_wb_pkg::A1_BASE,
  parameter int unsigned BEATS_M0   = demux_seq_wb_pkg::BEATS_M0,
  parameter int unsigned BEATS_M1   = demux_seq_wb_pkg::BEATS_M1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_start,
  input  logic                    i_mode,
  input  logic                    i_valid,
  input  logic [4*DATA_WIDTH-1:0] i_data_o1,
  input  logic [4*DATA_WIDTH-1:0] i_data_o2,
  output logic [ADDR_WIDTH-1:0]   o_addr_a0,
  output logic [ADDR_WIDTH-1:0]   o_addr_a1,
  output logic [ADDR_WIDTH-1:0]   o_addr_b0,
  output logic [ADDR_WIDTH-1:0]   o_addr_c1,
  output logic                    o_we_a0,
  output logic                    o_we_a1,
  output logic                    o_we_b0,
  output logic                    o_we_c1,
  output logic [4*DATA_WIDTH-1:0] o_wdata_x0,
  output logic [4*DATA_WIDTH-1:0] o_wdata_x1,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  localparam int unsigned BMAX = (BEATS_M1 > BEATS_M0) ? BEATS_M1 : BEATS_M0;
  localparam int unsigned CW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, c1_q, c1_d;
  logic                    we_ab_q, we_ab_d, we_bc_q, we_bc_d;
  logic [4*DATA_WIDTH-1:0] x0_q, x0_d, x1_q, x1_d;
  logic [4*DATA_WIDTH-1:0] x0_map, x1_map;
  logic [CW-1:0]           cnt_last;
  logic [ADDR_WIDTH-1:0]   n_addr;

  demux_lane_map #(.DW(DATA_WIDTH)) u_lane_map (
    .i_o1 (i_data_o1),
    .i_o2 (i_data_o2),
    .o_x0 (x0_map),
    .o_x1 (x1_map)
  );

  assign cnt_last = (mode_q == MODE_BC) ? CW'(BEATS_M1 - 1) : CW'(BEATS_M0 - 1);
  assign n_addr   = ADDR_WIDTH'(cnt_q);

  // Next-state: enable gates everything, start overrides state, then FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    b0_d    = b0_q;
    c1_d    = c1_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    we_ab_d = 1'b0;
    we_bc_d = 1'b0;
    if (!i_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (i_start) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      mode_d  = i_mode;
      // A beat coinciding with start is dropped and flagged even though start clears the flag
      err_d   = i_valid;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_valid) err_d = 1'b1;
        end
        ST_RUN: begin
          if (i_valid) begin
            x0_d = x0_map;
            x1_d = x1_map;
            if (mode_q == MODE_BC) begin
              b0_d    = n_addr;
              c1_d    = n_addr;
              we_bc_d = 1'b1;
            end else begin
              a0_d    = n_addr;
              a1_d    = ADDR_WIDTH'(A1_BASE) + n_addr;
              we_ab_d = 1'b1;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == cnt_last) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_valid) err_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered write-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_A;
      err_q   <= 1'b0;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      c1_q    <= '0;
      we_ab_q <= 1'b0;
      we_bc_q <= 1'b0;
      x0_q    <= '0;
      x1_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      b0_q    <= b0_d;
      c1_q    <= c1_d;
      we_ab_q <= we_ab_d;
      we_bc_q <= we_bc_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
    end
  end

  assign o_addr_a0  = a0_q;
  assign o_addr_a1  = a1_q;
  assign o_addr_b0  = b0_q;
  assign o_addr_c1  = c1_q;
  assign o_we_a0    = we_ab_q;
  assign o_we_a1    = we_ab_q;
  assign o_we_b0    = we_bc_q;
  assign o_we_c1    = we_bc_q;
  assign o_wdata_x0 = x0_q;
  assign o_wdata_x1 = x1_q;
  assign o_busy     = (state_q == ST_RUN);
  assign o_done     = (state_q == ST_DONE);
  assign o_err      = err_q;

endmodule

// File: tb/tb_demux_seq_wb.sv
// Directed bench for demux_seq_wb: full jobs in both modes, gaps, errors, restart, disable, reset.
module tb_demux_seq_wb;

  logic         clk, rst_n;
  logic         i_en, i_start, i_mode, i_valid;
  logic [255:0] i_data_o1, i_data_o2;
  logic [11:0]  o_addr_a0, o_addr_a1, o_addr_b0, o_addr_c1;
  logic         o_we_a0, o_we_a1, o_we_b0, o_we_c1;
  logic [255:0] o_wdata_x0, o_wdata_x1;
  logic         o_busy, o_done, o_err;

  int tests;
  int fails;

  demux_seq_wb #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (12),
    .A1_BASE    (2048),
    .BEATS_M0   (2048),
    .BEATS_M1   (4096)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (i_en),
    .i_start    (i_start),
    .i_mode     (i_mode),
    .i_valid    (i_valid),
    .i_data_o1  (i_data_o1),
    .i_data_o2  (i_data_o2),
    .o_addr_a0  (o_addr_a0),
    .o_addr_a1  (o_addr_a1),
    .o_addr_b0  (o_addr_b0),
    .o_addr_c1  (o_addr_c1),
    .o_we_a0    (o_we_a0),
    .o_we_a1    (o_we_a1),
    .o_we_b0    (o_we_b0),
    .o_we_c1    (o_we_c1),
    .o_wdata_x0 (o_wdata_x0),
    .o_wdata_x1 (o_wdata_x1),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane value: lane index tag in the top byte, payload in the low 32 bits
  function automatic logic [63:0] lv(input int k, input int v);
    return {8'(k), 24'h0, 32'(v)};
  endfunction

  function automatic logic [255:0] grp(input int v);
    return {lv(3, v), lv(2, v), lv(1, v), lv(0, v)};
  endfunction

  // Bank images for beat n with o1 lanes = 2n and o2 lanes = 2n+1
  function automatic logic [255:0] exp_x0(input int n);
    return {lv(2, 2*n+1), lv(2, 2*n), lv(0, 2*n+1), lv(0, 2*n)};
  endfunction

  function automatic logic [255:0] exp_x1(input int n);
    return {lv(3, 2*n+1), lv(3, 2*n), lv(1, 2*n+1), lv(1, 2*n)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic st, input logic md, input logic vl, input int n);
    i_en      = en;
    i_start   = st;
    i_mode    = md;
    i_valid   = vl;
    i_data_o1 = grp(2*n);
    i_data_o2 = grp(2*n+1);
  endtask

  task automatic test_reset();
    tests++;
    if ({o_addr_a0, o_addr_a1, o_addr_b0, o_addr_c1} !== 48'h0 ||
        {o_we_a0, o_we_a1, o_we_b0, o_we_c1, o_busy, o_done, o_err} !== 7'b0 ||
        o_wdata_x0 !== 256'h0 || o_wdata_x1 !== 256'h0) begin
      fails++;
      $display("FAIL reset_state: addr=%h/%h/%h/%h flags=%b busy=%b done=%b err=%b required all zero",
               o_addr_a0, o_addr_a1, o_addr_b0, o_addr_c1,
               {o_we_a0, o_we_a1, o_we_b0, o_we_c1}, o_busy, o_done, o_err);
    end
  endtask

  task automatic test_mode0_full();
    int ndone;
    ndone = 0;
    drive(1, 1, 0, 0, 0);
    tick();
    tests++;
    if (o_busy !== 1'b1 || o_we_a0 !== 1'b0 || o_err !== 1'b0) begin
      fails++;
      $display("FAIL m0_start: busy=%b we_a0=%b err=%b required 1 0 0", o_busy, o_we_a0, o_err);
    end
    for (int n = 0; n < 2048; n++) begin
      drive(1, 0, 0, 1, n);
      tick();
      if (o_done) ndone++;
      tests++;
      if (o_we_a0 !== 1'b1 || o_we_a1 !== 1'b1 || o_we_b0 !== 1'b0 || o_we_c1 !== 1'b0 ||
          o_addr_a0 !== 12'(n) || o_addr_a1 !== 12'(2048 + n) || o_done !== (n == 2047)) begin
        fails++;
        $display("FAIL m0_beat n=%0d: we=%b a0=%0d a1=%0d done=%b required we=1100 a0=%0d a1=%0d done=%b",
                 n, {o_we_a0, o_we_a1, o_we_b0, o_we_c1}, o_addr_a0, o_addr_a1, o_done,
                 n, 2048 + n, n == 2047);
      end
      if (n == 0 || n == 777 || n == 2047) begin
        tests++;
        if (o_wdata_x0 !== exp_x0(n) || o_wdata_x1 !== exp_x1(n)) begin
          fails++;
          $display("FAIL m0_data n=%0d: x0=%h x1=%h required x0=%h x1=%h",
                   n, o_wdata_x0, o_wdata_x1, exp_x0(n), exp_x1(n));
        end
      end
    end
    drive(1, 0, 0, 0, 0);
    tick();
    if (o_done) ndone++;
    tests++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_we_a0 !== 1'b0 || ndone != 1) begin
      fails++;
      $display("FAIL m0_end: done=%b busy=%b we_a0=%b pulses=%0d required 0 0 0 1",
               o_done, o_busy, o_we_a0, ndone);
    end
  endtask

  task automatic test_mode1_gaps();
    drive(1, 1, 1, 0, 0);
    tick();
    for (int n = 0; n < 4096; n++) begin
      if (n > 0 && n % 100 == 0) begin
        for (int g = 0; g < 3; g++) begin
          drive(1, 0, 1, 0, n);
          tick();
          tests++;
          if (o_we_b0 !== 1'b0 || o_we_c1 !== 1'b0 || o_addr_b0 !== 12'(n - 1) ||
              o_busy !== 1'b1 || o_done !== 1'b0) begin
            fails++;
            $display("FAIL m1_gap n=%0d: we_b0=%b we_c1=%b b0=%0d busy=%b done=%b required 0 0 %0d 1 0",
                     n, o_we_b0, o_we_c1, o_addr_b0, o_busy, o_done, n - 1);
          end
        end
      end
      drive(1, 0, 1, 1, n);
      tick();
      tests++;
      if (o_we_b0 !== 1'b1 || o_we_c1 !== 1'b1 || o_we_a0 !== 1'b0 || o_we_a1 !== 1'b0 ||
          o_addr_b0 !== 12'(n) || o_addr_c1 !== 12'(n) || o_done !== (n == 4095) ||
          o_wdata_x0 !== exp_x0(n)) begin
        fails++;
        $display("FAIL m1_beat n=%0d: we=%b b0=%0d c1=%0d done=%b x0=%h required we=0011 b0=c1=%0d done=%b x0=%h",
                 n, {o_we_a0, o_we_a1, o_we_b0, o_we_c1}, o_addr_b0, o_addr_c1, o_done,
                 o_wdata_x0, n, n == 4095, exp_x0(n));
      end
    end
    drive(1, 0, 1, 0, 0);
    tick();
    tests++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_we_b0 !== 1'b0 || o_addr_b0 !== 12'hfff) begin
      fails++;
      $display("FAIL m1_end: done=%b busy=%b we_b0=%b b0=%h required 0 0 0 fff",
               o_done, o_busy, o_we_b0, o_addr_b0);
    end
  endtask

  task automatic test_idle_valid();
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 0, 1, c);
      tick();
      tests++;
      if ({o_we_a0, o_we_a1, o_we_b0, o_we_c1} !== 4'b0 || o_err !== 1'b1 || o_busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_valid c=%0d: we=%b err=%b busy=%b required 0000 1 0",
                 c, {o_we_a0, o_we_a1, o_we_b0, o_we_c1}, o_err, o_busy);
      end
    end
    drive(1, 1, 0, 0, 0);
    tick();
    tests++;
    if (o_err !== 1'b0 || o_busy !== 1'b1) begin
      fails++;
      $display("FAIL idle_start_clears_err: err=%b busy=%b required 0 1", o_err, o_busy);
    end
    drive(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_restart();
    drive(1, 1, 0, 0, 0);
    tick();
    for (int n = 0; n < 1000; n++) begin
      drive(1, 0, 0, 1, n);
      tick();
    end
    tests++;
    if (o_addr_a0 !== 12'd999 || o_we_a0 !== 1'b1) begin
      fails++;
      $display("FAIL restart_pre: a0=%0d we_a0=%b required 999 1", o_addr_a0, o_we_a0);
    end
    drive(1, 1, 1, 1, 1000);
    tick();
    tests++;
    if (o_err !== 1'b1 || {o_we_a0, o_we_a1, o_we_b0, o_we_c1} !== 4'b0 || o_busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_drop: err=%b we=%b busy=%b required 1 0000 1",
               o_err, {o_we_a0, o_we_a1, o_we_b0, o_we_c1}, o_busy);
    end
    drive(1, 0, 1, 1, 5);
    tick();
    tests++;
    if (o_we_b0 !== 1'b1 || o_we_c1 !== 1'b1 || o_we_a0 !== 1'b0 || o_addr_b0 !== 12'd0 ||
        o_addr_c1 !== 12'd0 || o_err !== 1'b1 || o_wdata_x1 !== exp_x1(5)) begin
      fails++;
      $display("FAIL restart_first: we=%b b0=%0d c1=%0d err=%b x1=%h required 0011 0 0 1 %h",
               {o_we_a0, o_we_a1, o_we_b0, o_we_c1}, o_addr_b0, o_addr_c1, o_err,
               o_wdata_x1, exp_x1(5));
    end
    drive(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_enable_low();
    drive(1, 1, 0, 1, 0);
    tick();
    tests++;
    if (o_err !== 1'b1) begin
      fails++;
      $display("FAIL en_start_valid: err=%b required 1", o_err);
    end
    for (int n = 0; n < 500; n++) begin
      drive(1, 0, 0, 1, n);
      tick();
    end
    drive(0, 0, 0, 1, 500);
    tick();
    tests++;
    if ({o_we_a0, o_we_a1, o_we_b0, o_we_c1} !== 4'b0 || o_busy !== 1'b0 ||
        o_done !== 1'b0 || o_err !== 1'b1 || o_addr_a0 !== 12'd499) begin
      fails++;
      $display("FAIL en_low: we=%b busy=%b done=%b err=%b a0=%0d required 0000 0 0 1 499",
               {o_we_a0, o_we_a1, o_we_b0, o_we_c1}, o_busy, o_done, o_err, o_addr_a0);
    end
    for (int c = 0; c < 2; c++) begin
      drive(c == 1, 0, 0, 0, 0);
      tick();
      tests++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_we_a0 !== 1'b0) begin
        fails++;
        $display("FAIL en_low_after c=%0d: busy=%b done=%b we_a0=%b required 0 0 0",
                 c, o_busy, o_done, o_we_a0);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 1, 0, 0);
    tick();
    for (int n = 0; n < 300; n++) begin
      drive(1, 0, 1, 1, n);
      tick();
    end
    drive(1, 0, 1, 1, 300);
    #2;
    rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    drive(1, 0, 1, 1, 301);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 1, 1, 302);
    tick();
    tests++;
    if (o_busy !== 1'b0 || o_we_b0 !== 1'b0 || o_done !== 1'b0 || o_addr_b0 !== 12'd0) begin
      fails++;
      $display("FAIL post_reset_idle: busy=%b we_b0=%b done=%b b0=%0d required 0 0 0 0",
               o_busy, o_we_b0, o_done, o_addr_b0);
    end
    drive(1, 1, 1, 0, 0);
    tick();
    drive(1, 0, 1, 1, 9);
    tick();
    tests++;
    if (o_we_b0 !== 1'b1 || o_addr_b0 !== 12'd0 || o_wdata_x0 !== exp_x0(9)) begin
      fails++;
      $display("FAIL post_reset_job: we_b0=%b b0=%0d x0=%h required 1 0 %h",
               o_we_b0, o_addr_b0, o_wdata_x0, exp_x0(9));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #23;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0);
    tick();
    test_mode0_full();
    test_mode1_gaps();
    test_idle_valid();
    test_restart();
    test_enable_low();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
